// File: rtl/hash_writer_pkg.sv
// rtl/hash_writer_pkg.sv - shared SHA block constants: job sizing defaults and writer FSM encodings
package hash_writer_pkg;

  // Default number of per-nonce hash words produced by one job
  localparam int HW_NUM_NONCES = 16;

  // Default memory address width
  localparam int HW_ADDR_W = 16;

  // Writer FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Width of an index able to address n entries; never narrower than one bit
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hash_writer.sv
// rtl/hash_writer.sv - collects per-nonce hash words and streams them to memory one word per grant
module hash_writer
  import hash_writer_pkg::*;
#(
  parameter int NUM_NONCES = HW_NUM_NONCES,
  parameter int ADDR_W     = HW_ADDR_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       output_addr,
  input  logic                    hout_valid,
  input  logic [NUM_NONCES*32-1:0] hout,
  input  logic                    mem_grant,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [31:0]             mem_write_data,
  output logic                    busy,
  output logic                    done
);

  localparam int               IDX_W    = idx_width(NUM_NONCES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NONCES - 1);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_base;
  logic [IDX_W-1:0]  r_idx;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_data;
  logic              r_done;
  logic [31:0]       r_buf [NUM_NONCES];

  logic              w_accept;
  logic              w_capture;
  logic [IDX_W-1:0]  w_idx_next;

  // A write retires only when it is presented and granted in the same cycle
  assign w_accept   = r_mem_we & mem_grant;
  assign w_capture  = (r_state == ST_WAIT) & hout_valid;
  assign w_idx_next = r_idx + IDX_W'(1);

  assign mem_we         = r_mem_we;
  assign mem_addr       = r_mem_addr;
  assign mem_write_data = r_mem_data;
  assign done           = r_done;
  assign busy           = (r_state != ST_IDLE);

  // Hash word buffer: loaded only on the WAIT-state capture, otherwise frozen
  always_ff @(posedge clk) begin
    if (reset_n && w_capture) begin
      for (int i = 0; i < NUM_NONCES; i++) begin
        r_buf[i] <= hout[i*32 +: 32];
      end
    end
  end

  // Job sequencing and registered write port
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_base     <= '0;
      r_idx      <= '0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // hout_valid alongside start is deliberately ignored here
          if (start) begin
            r_base  <= output_addr;
            r_idx   <= '0;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // First word comes straight from the input so it is presented
          // the cycle right after capture, while the buffer loads in parallel
          if (hout_valid) begin
            r_idx      <= '0;
            r_mem_we   <= 1'b1;
            r_mem_addr <= r_base;
            r_mem_data <= hout[31:0];
            r_state    <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // Without a grant every write output simply holds its value
          if (w_accept) begin
            if (r_idx == LAST_IDX) begin
              r_mem_we <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= ST_DONE;
            end else begin
              r_idx      <= w_idx_next;
              r_mem_addr <= r_base + ADDR_W'(w_idx_next);
              r_mem_data <= r_buf[w_idx_next];
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_mem_we <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hash_writer.sv
// tb/tb_hash_writer.sv - directed vector bench for hash_writer
module tb_hash_writer;

  localparam int N  = 16;
  localparam int AW = 16;

  logic            clk;
  logic            reset_n;
  logic            start;
  logic [AW-1:0]   output_addr;
  logic            hout_valid;
  logic [N*32-1:0] hout;
  logic            mem_grant;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [31:0]     mem_write_data;
  logic            busy;
  logic            done;

  int total = 0;
  int bad   = 0;

  hash_writer #(.NUM_NONCES(N), .ADDR_W(AW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .output_addr   (output_addr),
    .hout_valid    (hout_valid),
    .hout          (hout),
    .mem_grant     (mem_grant),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_write_data(mem_write_data),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] base;
    logic [31:0] seed;
    int          stall_idx;
    int          stall_len;
    int          inj_idx;
    bit          both;
    logic [15:0] exp_first;
    logic [15:0] exp_last;
    int          exp_lat;
    int          exp_hold;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic load_hout(input logic [31:0] seed);
    for (int i = 0; i < N; i++) hout[i*32 +: 32] = seed + 32'(i);
  endtask

  task automatic run_job(input vec_t t);
    logic [15:0] exp_addr;
    logic [15:0] last_addr;
    int nidx, stalls, hold, lat;
    bit acc, done_seen, inj_done;
    nidx = 0; stalls = 0; hold = 0; lat = 0;
    done_seen = 0; inj_done = 0; last_addr = '0;

    start = 1'b1;
    output_addr = t.base;
    if (t.both) begin
      hout_valid = 1'b1;
      load_hout(32'hEEEE_0000);
    end
    tick();
    start = 1'b0;
    hout_valid = 1'b0;
    chk("start_busy", busy, 1'b1);
    chk("start_we", mem_we, 1'b0);
    repeat (3) tick();
    chk("wait_we", mem_we, 1'b0);
    chk("wait_busy", busy, 1'b1);

    load_hout(t.seed);
    hout_valid = 1'b1;
    tick();
    hout_valid = 1'b0;
    load_hout(~t.seed);
    chk("first_we", mem_we, 1'b1);
    chk("first_addr", mem_addr, t.exp_first);

    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (done) begin
        lat = cyc;
        chk("done_we", mem_we, 1'b0);
        chk("write_count", nidx, N);
        done_seen = 1;
        break;
      end
      chk("we_held", mem_we, 1'b1);
      exp_addr = t.base + 16'(nidx);
      chk("wr_addr", mem_addr, exp_addr);
      chk("wr_data", mem_write_data, t.seed + 32'(nidx));
      if (nidx == t.stall_idx) hold++;
      last_addr = mem_addr;
      if (nidx == t.inj_idx && !inj_done) begin
        start = 1'b1;
        output_addr = 16'h7777;
        hout_valid = 1'b1;
        load_hout(32'hBAD0_0000);
        inj_done = 1;
      end
      if (nidx == t.stall_idx && stalls < t.stall_len) begin
        mem_grant = 1'b0;
        stalls++;
      end else begin
        mem_grant = 1'b1;
      end
      acc = mem_we && mem_grant;
      tick();
      start = 1'b0;
      hout_valid = 1'b0;
      mem_grant = 1'b1;
      if (acc) nidx++;
    end

    if (!done_seen) chk("done_timeout", 32'd0, 32'd1);
    chk("latency", lat, t.exp_lat);
    chk("hold_cycles", hold, t.exp_hold);
    chk("last_addr", last_addr, t.exp_last);
    tick();
    chk("done_one_cycle", done, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_we", mem_we, 1'b0);
  endtask

  initial begin
    int stray;
    bit hit;

    vecs[0] = '{16'h0010, 32'hA000_0000,  0, 0, -1, 1'b0, 16'h0010, 16'h001F, 17, 1};
    vecs[1] = '{16'h0010, 32'hA000_0000,  5, 3, -1, 1'b0, 16'h0010, 16'h001F, 20, 4};
    vecs[2] = '{16'hFFFA, 32'h1234_0000,  0, 0, -1, 1'b0, 16'hFFFA, 16'h0009, 17, 1};
    vecs[3] = '{16'h8000, 32'hDEAD_0000,  0, 2, -1, 1'b0, 16'h8000, 16'h800F, 19, 3};
    vecs[4] = '{16'hFFFF, 32'h0000_0000, 15, 1, -1, 1'b0, 16'hFFFF, 16'h000E, 18, 2};
    vecs[5] = '{16'h0100, 32'h5000_0000,  0, 0,  3, 1'b0, 16'h0100, 16'h010F, 17, 1};
    vecs[6] = '{16'h0200, 32'hC000_0000,  0, 0, -1, 1'b1, 16'h0200, 16'h020F, 17, 1};

    reset_n = 1'b0;
    start = 1'b0;
    output_addr = '0;
    hout_valid = 1'b0;
    hout = '0;
    mem_grant = 1'b1;
    tick();
    tick();
    chk("rst_we", mem_we, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_data", mem_write_data, 32'h0);
    reset_n = 1'b1;
    tick();

    for (int v = 0; v < 7; v++) begin
      run_job(vecs[v]);
      tick();
    end

    // Reset while index 7 is being presented aborts the job
    start = 1'b1;
    output_addr = 16'h0300;
    tick();
    start = 1'b0;
    load_hout(32'h1111_0000);
    hout_valid = 1'b1;
    tick();
    hout_valid = 1'b0;
    hit = 0;
    for (int c = 0; c < 40; c++) begin
      if (mem_we && mem_addr == 16'h0307) begin
        hit = 1;
        break;
      end
      tick();
    end
    chk("rst_mid_reach_idx7", hit, 1'b1);
    chk("rst_mid_data7", mem_write_data, 32'h1111_0007);
    reset_n = 1'b0;
    tick();
    chk("rst_mid_we", mem_we, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_done", done, 1'b0);
    chk("rst_mid_addr", mem_addr, 16'h0000);
    reset_n = 1'b1;
    stray = 0;
    repeat (20) begin
      tick();
      if (mem_we || done || busy) stray++;
    end
    chk("rst_mid_quiet", stray, 0);

    run_job(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
